mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmit peripheral on the hart's MMIO write port.
- Consumes memory_mapped_io_control, split into addr, value, width and enable.
- Drives memory_mapped_io_write_complete and memory_mapped_io_r_data back to the hart.
- Buffers bytes written by software in a small FIFO and serializes them as 8N1 frames on a single TX line.

Parameters:
- BASE_ADDR, 32'h8000_0000: base of the 16-byte register window. Must be 16-byte aligned.
- FIFO_DEPTH, 8: TX FIFO entries. Power of two, at least 2.
- DIVISOR_WIDTH, 16: width of the baud divisor register.
- DEFAULT_DIVISOR, 16'd434: divisor value at reset.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; asserted when 0.
- mmio_addr  in  XLEN  byte address (memory_mapped_io_control.addr).
- mmio_value  in  XLEN  write data (.value).
- mmio_width  in  mem_width_t  access width (.width); ignored, low bits of mmio_value are used.
- mmio_enable  in  1  write request (.enable).
- mmio_write_complete  out  1  write accepted this cycle.
- mmio_r_data  out  XLEN  read data for mmio_addr; combinational.
- uart_tx  out  1  serial output; idles high.
- tx_busy  out  1  frame in progress or FIFO non-empty.

Behaviour:
- Register map (offset = mmio_addr - BASE_ADDR; only addr[3:2] decoded inside the window):
  - 0x0 TXDATA: write pushes value[7:0]. Reads 0.
  - 0x4 STATUS: read-only. bit0 fifo_full, bit1 fifo_empty, bit2 tx_busy, bits[11:8] fifo count; other bits 0.
  - 0x8 DIVISOR: read/write, value[DIVISOR_WIDTH-1:0].
  - 0xC: reserved; reads 0, writes ignored.
- Addresses outside the window: r_data 0; writes complete and are ignored.
- Write handshake:
  - write_complete = enable && !(hits TXDATA && fifo_full). Combinational, same cycle.
  - State updates at the rising edge where enable && write_complete.
  - A TXDATA write with the FIFO full holds write_complete low (the hart stalls) until a slot frees.
  - When the serializer pops in a cycle with a full FIFO, write_complete rises the next cycle, not the same one. No same-cycle pass-through.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo FIFO_DEPTH.
  - Count is tracked separately so full and empty are unambiguous.
  - Simultaneous push and pop: count unchanged, both pointers advance.
- Serializer FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: uart_tx=1. If FIFO non-empty, pop the head into the shift register, latch divisor_eff = max(DIVISOR,1), go to START.
  - START: uart_tx=0 for divisor_eff cycles.
  - DATA: 8 bits, LSB first, divisor_eff cycles each. A 3-bit index and a DIVISOR_WIDTH-bit bit-timer count.
  - STOP: uart_tx=1 for divisor_eff cycles. Then IDLE. If the FIFO is non-empty, the next START begins 1 cycle later (one IDLE cycle between frames).
  - DIVISOR writes mid-frame take effect from the next frame only.
- tx_busy = (state != IDLE) || !fifo_empty.
- Reset (reset==0 at a rising edge):
  - State IDLE, FIFO emptied, pointers 0, DIVISOR = DEFAULT_DIVISOR.
  - uart_tx=1, tx_busy=0; write_complete follows its equation.
  - Reset mid-frame aborts the frame immediately; uart_tx is high on the next cycle.
  - Writes are ignored while reset is asserted.

Optional Feature:
- Macro: MMIO_UART_TX_SIM_PRINT_EN.
- Defined: each accepted TXDATA write also calls $write("%c", value[7:0]) at that edge. Simulation only; the hardware path is unchanged.
- Undefined: no system tasks are compiled; the block is fully synthesizable.

Test Plan:
- Reset with DIVISOR read -> r_data=0x1B2 (434). STATUS = 0x002 (empty, count 0); uart_tx=1.
- Write DIVISOR=4, then TXDATA=0x55 -> after 1 idle cycle, uart_tx sequence is 0 (start), then 1,0,1,0,1,0,1,0, then 1 (stop), each held 4 cycles, 40 cycles total. tx_busy drops after stop.
- Divisor 4, write 9 bytes back-to-back -> writes 1-8 complete in consecutive cycles; the 9th stalls with write_complete=0 until the first pop, then completes. STATUS count reads 8 while full.
- DIVISOR=0 with byte 0xA5 -> each bit lasts 1 cycle. Writing DIVISOR=10 mid-frame leaves the current frame at 1 cycle/bit; the next frame uses 10.
- Reset asserted during DATA bit 3 -> the next cycle shows uart_tx=1, STATUS=0x002, and queued bytes are discarded.
- Write to BASE_ADDR+0xC and to BASE_ADDR+0x40 -> write_complete=1 in the same cycle, no state change, and reads return 0.

Source files
------------

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: hart MMIO write-port bundle (memory_mapped_io_control split
// into addr/value/width/enable, plus write_complete and r_data back to the hart).
//   master: hart side, drives addr/value/width/enable.
//   slave : peripheral side, drives write_complete and r_data.
interface mmio_uart_tx_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] mmio_addr;
  logic [XLEN-1:0] mmio_value;
  logic [1:0]      mmio_width;
  logic            mmio_enable;
  logic            mmio_write_complete;
  logic [XLEN-1:0] mmio_r_data;

  modport master (
    output mmio_addr, mmio_value, mmio_width, mmio_enable,
    input  mmio_write_complete, mmio_r_data
  );

  modport slave (
    input  mmio_addr, mmio_value, mmio_width, mmio_enable,
    output mmio_write_complete, mmio_r_data
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter. Software writes bytes to TXDATA,
// they are queued in a FIFO and sent as 8N1 frames on uart_tx.
// Ports:
//   clock   - rising-edge clock
//   reset   - synchronous, active-low
//   bus     - MMIO slave (addr/value/width/enable in, write_complete/r_data out)
//   uart_tx - serial output, idles high
//   tx_busy - frame in progress or FIFO non-empty
// Register window at BASE_ADDR (addr[3:2] decoded):
//   0x0 TXDATA (W, reads 0), 0x4 STATUS (R), 0x8 DIVISOR (R/W), 0xC reserved.
// Optional: define MMIO_UART_TX_SIM_PRINT_EN to echo accepted TXDATA bytes with
// $write in simulation.
module mmio_uart_tx #(
  parameter logic [31:0]              BASE_ADDR       = 32'h8000_0000,
  parameter int unsigned              FIFO_DEPTH      = 8,
  parameter int unsigned              DIVISOR_WIDTH   = 16,
  parameter logic [DIVISOR_WIDTH-1:0] DEFAULT_DIVISOR = 16'd434
) (
  input  logic             clock,
  input  logic             reset,
  mmio_uart_tx_if.slave    bus,
  output logic             uart_tx,
  output logic             tx_busy
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CW   = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                   state_q, state_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [DIVISOR_WIDTH-1:0] divisor_q, divisor_d;
  logic [DIVISOR_WIDTH-1:0] div_eff_q, div_eff_d;
  logic [DIVISOR_WIDTH-1:0] timer_q, timer_d;
  logic [2:0]               bit_idx_q, bit_idx_d;
  logic [7:0]               shift_q, shift_d;
  logic                     tx_q, tx_d;
  logic [7:0]               mem_q [FIFO_DEPTH];

  logic            in_window, hit_txdata, fifo_full, fifo_empty;
  logic            accept, push, pop, div_wr, timer_done;
  logic [1:0]      sel;
  logic [XLEN-1:0] status_word;
  logic            unused_bits;

  assign in_window  = bus.mmio_addr[XLEN-1:4] == BASE_ADDR[XLEN-1:4];
  assign sel        = bus.mmio_addr[3:2];
  assign fifo_full  = count_q == CW'(FIFO_DEPTH);
  assign fifo_empty = count_q == '0;
  assign hit_txdata = in_window && (sel == 2'd0);

  // Stall depends only on the registered count, so a pop never frees a slot
  // for a write in the same cycle.
  assign bus.mmio_write_complete = bus.mmio_enable && !(hit_txdata && fifo_full);
  assign accept = bus.mmio_enable && bus.mmio_write_complete;
  assign push   = accept && hit_txdata;
  assign div_wr = accept && in_window && (sel == 2'd2);
  assign pop    = (state_q == S_IDLE) && !fifo_empty;

  assign timer_done = timer_q == (div_eff_q - DIVISOR_WIDTH'(1));

  assign tx_busy = (state_q != S_IDLE) || !fifo_empty;
  assign uart_tx = tx_q;

  assign unused_bits = ^{bus.mmio_width, bus.mmio_addr[1:0], bus.mmio_value};

  always_comb begin
    status_word       = '0;
    status_word[0]    = fifo_full;
    status_word[1]    = fifo_empty;
    status_word[2]    = tx_busy;
    status_word[11:8] = 4'(count_q);
  end

  always_comb begin
    bus.mmio_r_data = '0;
    if (in_window) begin
      case (sel)
        2'd1:    bus.mmio_r_data = status_word;
        2'd2:    bus.mmio_r_data = XLEN'(divisor_q);
        default: bus.mmio_r_data = '0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    divisor_d = divisor_q;
    div_eff_d = div_eff_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (div_wr) divisor_d = bus.mmio_value[DIVISOR_WIDTH-1:0];

    // tx_d is the line level for the state being entered, so uart_tx is a flop.
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          shift_d   = mem_q[rd_ptr_q];
          div_eff_d = (divisor_q == '0) ? DIVISOR_WIDTH'(1) : divisor_q;
          timer_d   = '0;
          state_d   = S_START;
          tx_d      = 1'b0;
        end
      end
      S_START: begin
        if (timer_done) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
          tx_d      = shift_q[0];
        end else begin
          timer_d = timer_q + DIVISOR_WIDTH'(1);
        end
      end
      S_DATA: begin
        if (timer_done) begin
          timer_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          timer_d = timer_q + DIVISOR_WIDTH'(1);
        end
      end
      S_STOP: begin
        if (timer_done) begin
          timer_d = '0;
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end else begin
          timer_d = timer_q + DIVISOR_WIDTH'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      divisor_q <= DEFAULT_DIVISOR;
      div_eff_q <= DIVISOR_WIDTH'(1);
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      divisor_q <= divisor_d;
      div_eff_q <= div_eff_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clock) begin
    if (reset && push) mem_q[wr_ptr_q] <= bus.mmio_value[7:0];
  end

`ifdef MMIO_UART_TX_SIM_PRINT_EN
  always_ff @(posedge clock) begin
    if (reset && push) $write("%c", bus.mmio_value[7:0]);
  end
`else
`endif

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

  localparam logic [31:0] B       = 32'h8000_0000;
  localparam logic [31:0] A_TX    = B + 32'h0;
  localparam logic [31:0] A_STAT  = B + 32'h4;
  localparam logic [31:0] A_DIV   = B + 32'h8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic uart_tx, tx_busy;

  mmio_uart_tx_if bus ();

  mmio_uart_tx dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .uart_tx (uart_tx),
    .tx_busy (tx_busy)
  );

  always #5 clock = ~clock;

  int   cyc = 0;
  logic tx_hist   [4096];
  logic busy_hist [4096];

  always @(posedge clock) cyc = cyc + 1;
  always @(negedge clock) begin
    if (cyc < 4096) begin
      tx_hist[cyc]   = uart_tx;
      busy_hist[cyc] = tx_busy;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_edge(input int n);
    while (cyc < n) tick();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v, output int edge_n);
    bus.mmio_addr   = a;
    bus.mmio_value  = v;
    bus.mmio_enable = 1'b1;
    @(negedge clock);
    chk("wr_complete", 32'(bus.mmio_write_complete), 32'd1);
    tick();
    edge_n          = cyc;
    bus.mmio_enable = 1'b0;
  endtask

  // Frame popped at edge p: phase k occupies tx_hist[p+k*d .. p+k*d+d-1].
  task automatic check_frame(input string nm, input int p, input logic [7:0] b, input int d);
    logic e;
    for (int k = 0; k < 10; k++) begin
      e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      chk($sformatf("%s_ph%0d_first", nm, k), 32'(tx_hist[p + k*d]), 32'(e));
      chk($sformatf("%s_ph%0d_last", nm, k), 32'(tx_hist[p + k*d + d - 1]), 32'(e));
    end
    chk($sformatf("%s_idle_after", nm), 32'(tx_hist[p + 10*d]), 32'd1);
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic [31:0] addr;
    logic [31:0] value;
    logic        exp_wc;
    logic [31:0] exp_rd;
    logic        exp_tx;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e, w, stall, t;
    bit done;

    vecs[0]  = '{1'b1, 1'b0, A_DIV,        32'h0,         1'b0, 32'h1B2, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, A_STAT,       32'h0,         1'b0, 32'h002, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, A_TX,         32'h0,         1'b0, 32'h000, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, B + 32'hC,    32'hFF,        1'b1, 32'h000, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, B + 32'h40,   32'h12,        1'b1, 32'h000, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, A_DIV,        32'h0,         1'b0, 32'h1B2, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, A_STAT,       32'h0,         1'b0, 32'h002, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, A_DIV,        32'hFFFF_0007, 1'b1, 32'h1B2, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, A_DIV,        32'h0,         1'b0, 32'h007, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, A_DIV,        32'h4,         1'b1, 32'h007, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, B + 32'h48,   32'h0,         1'b0, 32'h000, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, A_STAT,       32'h0,         1'b0, 32'h002, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, A_DIV,        32'h9,         1'b1, 32'h004, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b0, A_DIV,        32'h0,         1'b0, 32'h1B2, 1'b1, 1'b0};

    bus.mmio_addr   = A_DIV;
    bus.mmio_value  = '0;
    bus.mmio_width  = 2'd2;
    bus.mmio_enable = 1'b0;
    reset           = 1'b0;
    tick();
    tick();

    foreach (vecs[i]) begin
      reset           = vecs[i].rst;
      bus.mmio_enable = vecs[i].en;
      bus.mmio_addr   = vecs[i].addr;
      bus.mmio_value  = vecs[i].value;
      @(negedge clock);
      chk($sformatf("v%0d_wc", i),   32'(bus.mmio_write_complete), 32'(vecs[i].exp_wc));
      chk($sformatf("v%0d_rd", i),   bus.mmio_r_data,              vecs[i].exp_rd);
      chk($sformatf("v%0d_tx", i),   32'(uart_tx),                 32'(vecs[i].exp_tx));
      chk($sformatf("v%0d_busy", i), 32'(tx_busy),                 32'(vecs[i].exp_busy));
      tick();
    end
    reset           = 1'b1;
    bus.mmio_enable = 1'b0;

    // Single 0x55 frame at divisor 4, preceded by one idle cycle.
    wr(A_DIV, 32'd4, w);
    wr(A_TX, 32'h55, e);
    wait_edge(e + 1 + 42);
    chk("a_idle_gap", 32'(tx_hist[e]), 32'd1);
    check_frame("a55", e + 1, 8'h55, 4);
    chk("a_busy_in_stop", 32'(busy_hist[e + 1 + 39]), 32'd1);
    chk("a_busy_after",   32'(busy_hist[e + 1 + 40]), 32'd0);

    // Fill the FIFO behind an in-flight frame; the 9th write stalls.
    wr(A_TX, 32'h00, w);
    tick();
    tick();
    for (int i = 1; i <= 8; i++) wr(A_TX, 32'(i), e);
    bus.mmio_addr = A_STAT;
    @(negedge clock);
    chk("b_status_full", bus.mmio_r_data, 32'h0000_0805);
    tick();
    bus.mmio_addr   = A_TX;
    bus.mmio_value  = 32'h09;
    bus.mmio_enable = 1'b1;
    stall = 0;
    done  = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clock);
      if (bus.mmio_write_complete) done = 1'b1;
      else begin
        stall++;
        tick();
      end
    end
    chk("b_stall_seen", 32'(done), 32'd1);
    chk("b_stall_cycles", 32'(stall), 32'd31);
    tick();
    bus.mmio_enable = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clock);
      if (!tx_busy) done = 1'b1;
      else tick();
    end
    chk("b_drained", 32'(done), 32'd1);
    tick();

    // Divisor 0 acts as 1; a mid-frame divisor write applies to the next frame.
    wr(A_DIV, 32'd0, w);
    wr(A_TX, 32'hA5, e);
    wr(A_TX, 32'h3C, w);
    wr(A_DIV, 32'd10, w);
    wait_edge(e + 115);
    check_frame("c_a5", e + 1, 8'hA5, 1);
    check_frame("c_3c", e + 12, 8'h3C, 10);

    // Reset during DATA bit 3 aborts the frame and discards queued bytes.
    wr(A_DIV, 32'd4, w);
    wr(A_TX, 32'h00, e);
    wr(A_TX, 32'h11, w);
    wr(A_TX, 32'h22, w);
    wait_edge(e + 17);
    reset         = 1'b0;
    bus.mmio_addr = A_STAT;
    @(negedge clock);
    chk("d_tx_bit3", 32'(uart_tx), 32'd0);
    tick();
    reset = 1'b1;
    @(negedge clock);
    chk("d_tx_after_rst",   32'(uart_tx),        32'd1);
    chk("d_status_after",   bus.mmio_r_data,     32'h0000_0002);
    t = cyc;
    wait_edge(t + 5);
    @(negedge clock);
    chk("d_busy_later", 32'(tx_busy), 32'd0);
    chk("d_tx_later",   32'(uart_tx), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
